budget_rr_scheduler: RTL and testbench

// - Budget-regulated round-robin scheduler for the per-core packet queues; alternative to the multi-policy scheduler.
// - Grants one non-empty queue at a time to the serializer.
// - Holds each grant until the serializer reports consumption.
// - Limits each queue to a programmable number of grants per regulation period (MemGuard-style).
// - Drives the selector index, the serializer enable and the per-queue consume pulse.

---
 rtl/budget_rr_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_budget_rr_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/budget_rr_scheduler.sv
// Budget-regulated round-robin scheduler: grants one non-empty queue at a time and
// limits each queue to a programmable number of grants per period. Option: WORK_CONSERVING_EN.
module budget_rr_scheduler #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32,
    localparam int ID_W            = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic                                             clock_i,
    input  logic                                             reset_i,
    input  logic [NUMBER_OF_QUEUES-1:0]                      empty_i,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   budgets_i,
    input  logic [REGISTER_SIZE-1:0]                         period_i,
    input  logic                                             consumed_i,
    output logic [ID_W-1:0]                                  id_o,
    output logic                                             enable_o,
    output logic [NUMBER_OF_QUEUES-1:0]                      hasBeenConsumed_o,
    output logic [NUMBER_OF_QUEUES-1:0]                      throttled_o,
    output logic                                             state_o
);

    localparam int NQ = NUMBER_OF_QUEUES;
    localparam int RS = REGISTER_SIZE;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [ID_W-1:0]         last_q, last_d;
    logic                    enable_q, enable_d;
    logic [RS-1:0]           cnt_q, cnt_d;
    logic [NQ-1:0][RS-1:0]   remaining_q, remaining_d;

    logic                    regulate;
    logic                    wrap;
    logic                    consume_fire;
    logic                    decrement;
    logic [NQ-1:0]           eligible;
    logic                    pick_found;
    logic [ID_W-1:0]         pick_idx;

    // First requester strictly after 'last', searching circularly.
    function automatic logic [ID_W:0] rr_pick(input logic [NQ-1:0] req,
                                              input logic [ID_W-1:0] last);
        logic            found;
        logic [ID_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NQ; k++) begin
            int c;
            c = (int'(last) + k) % NQ;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = ID_W'(c);
            end
        end
        return {found, idx};
    endfunction

    assign regulate     = (period_i != '0);
    assign wrap         = regulate && (cnt_q >= (period_i - RS'(1)));
    assign consume_fire = (state_q == S_WAIT) && consumed_i;

    always_comb begin
        eligible    = '0;
        throttled_o = '0;
        for (int i = 0; i < NQ; i++) begin
            eligible[i]    = !empty_i[i] && (!regulate || (remaining_q[i] != '0));
            throttled_o[i] = regulate && (remaining_q[i] == '0);
        end
    end

    assign {pick_found, pick_idx} = rr_pick(eligible, last_q);

`ifdef WORK_CONSERVING_EN
    logic            slack_q, slack_d;
    logic            slack_found;
    logic [ID_W-1:0] slack_idx;

    assign {slack_found, slack_idx} = rr_pick(~empty_i, last_q);
    // Slack grants borrow idle bandwidth and are not charged to the budget.
    assign decrement = consume_fire && regulate && !slack_q;
`else
    assign decrement = consume_fire && regulate;
`endif

    // Handshake: enable_o/id_o form a held grant; the transfer completes on the
    // cycle consumed_i is high while enable_o is high, and only then may the grant change.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        last_d   = last_q;
        enable_d = enable_q;
`ifdef WORK_CONSERVING_EN
        slack_d  = slack_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    id_d     = pick_idx;
                    enable_d = 1'b1;
                    state_d  = S_WAIT;
`ifdef WORK_CONSERVING_EN
                    slack_d  = 1'b0;
                end else if (slack_found) begin
                    id_d     = slack_idx;
                    enable_d = 1'b1;
                    state_d  = S_WAIT;
                    slack_d  = 1'b1;
`endif
                end
            end
            S_WAIT: begin
                if (consumed_i) begin
                    enable_d = 1'b0;
                    last_d   = id_q;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                enable_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // Replenish at wrap takes priority over a coincident decrement.
    always_comb begin
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        if (!regulate || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + RS'(1);
        end
        if (wrap) begin
            remaining_d = budgets_i;
        end else if (decrement && (remaining_q[id_q] != '0)) begin
            remaining_d[id_q] = remaining_q[id_q] - RS'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            last_q      <= ID_W'(NQ - 1);
            enable_q    <= 1'b0;
            cnt_q       <= '0;
            remaining_q <= budgets_i;
`ifdef WORK_CONSERVING_EN
            slack_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            last_q      <= last_d;
            enable_q    <= enable_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
`ifdef WORK_CONSERVING_EN
            slack_q     <= slack_d;
`endif
        end
    end

    always_comb begin
        hasBeenConsumed_o = '0;
        if (consume_fire && !reset_i) begin
            hasBeenConsumed_o[id_q] = 1'b1;
        end
    end

    assign id_o     = id_q;
    assign enable_o = enable_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_budget_rr_scheduler.sv
// Bench for budget_rr_scheduler: scenario tasks with an expected-grant queue.
module tb_budget_rr_scheduler;

  localparam int NQ = 4;
  localparam int RS = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NQ-1:0]         empty;
  logic [NQ-1:0][RS-1:0] budgets;
  logic [RS-1:0]         period;
  logic                  consumed;
  logic [1:0]            id;
  logic                  enable;
  logic [NQ-1:0]         has_been_consumed;
  logic [NQ-1:0]         throttled;
  logic                  state;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_id;

  always #5 clk = ~clk;

  budget_rr_scheduler #(.NUMBER_OF_QUEUES(NQ), .REGISTER_SIZE(RS)) dut (
    .clock_i          (clk),
    .reset_i          (reset),
    .empty_i          (empty),
    .budgets_i        (budgets),
    .period_i         (period),
    .consumed_i       (consumed),
    .id_o             (id),
    .enable_o         (enable),
    .hasBeenConsumed_o(has_been_consumed),
    .throttled_o      (throttled),
    .state_o          (state)
  );

  task automatic set_budgets(input int b0, input int b1, input int b2, input int b3);
    budgets[0] = RS'(b0);
    budgets[1] = RS'(b1);
    budgets[2] = RS'(b2);
    budgets[3] = RS'(b3);
  endtask

  // Leaves the bench 1 time unit after the last reset edge.
  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_budgets(1, 1, 1, 1);
    period = '0;
    empty = 4'b1111;
    consumed = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (id !== 2'd0) begin miscompares++; $display("FAIL reset_id got=%0d exp=0", id); end
    vectors++;
    if (enable !== 1'b0) begin miscompares++; $display("FAIL reset_enable got=%b exp=0", enable); end
    vectors++;
    if (has_been_consumed !== 4'b0000) begin miscompares++; $display("FAIL reset_pop got=%b exp=0000", has_been_consumed); end
    vectors++;
    if (throttled !== 4'b0000) begin miscompares++; $display("FAIL reset_throttled got=%b exp=0000", throttled); end
    vectors++;
    if (state !== 1'b0) begin miscompares++; $display("FAIL reset_state got=%b exp=0", state); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic exp_en;
    set_budgets(1, 1, 1, 1);
    period = '0;
    empty = 4'b0000;
    consumed = 1'b1;
    apply_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      exp_en = (k % 2 == 1);
      vectors++;
      if (enable !== exp_en) begin miscompares++; $display("FAIL rr_enable k=%0d got=%b exp=%b", k, enable, exp_en); end
      vectors++;
      if (throttled !== 4'b0000) begin miscompares++; $display("FAIL rr_throttled k=%0d got=%b exp=0000", k, throttled); end
      if (enable === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rr_extra_grant k=%0d got=%0d exp=none", k, id);
        end else begin
          exp_id = exp_q.pop_front();
          if (id !== exp_id || has_been_consumed !== (4'b0001 << exp_id)) begin
            miscompares++;
            $display("FAIL rr_grant k=%0d got id=%0d pop=%b exp id=%0d", k, id, has_been_consumed, exp_id);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rr_missing got=%0d left exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_budget();
    logic exp_en;
    set_budgets(1, 1, 1, 2);
    period = RS'(100);
    empty = 4'b0000;
    consumed = 1'b1;
    apply_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2};
    for (int k = 1; k <= 106; k++) begin
      next_cycle();
      exp_en = (k % 2 == 1) && (k <= 9 || k >= 101);
      vectors++;
      if (enable !== exp_en) begin miscompares++; $display("FAIL budget_enable k=%0d got=%b exp=%b", k, enable, exp_en); end
      if (enable === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL budget_extra_grant k=%0d got=%0d exp=none", k, id);
        end else begin
          exp_id = exp_q.pop_front();
          if (id !== exp_id) begin miscompares++; $display("FAIL budget_grant k=%0d got=%0d exp=%0d", k, id, exp_id); end
        end
      end
      if (k == 9) begin
        vectors++;
        if (throttled !== 4'b0111) begin miscompares++; $display("FAIL budget_thr9 got=%b exp=0111", throttled); end
      end
      if (k >= 10 && k <= 99 && (k % 10 == 0 || k == 99)) begin
        vectors++;
        if (throttled !== 4'b1111) begin miscompares++; $display("FAIL budget_thr k=%0d got=%b exp=1111", k, throttled); end
      end
      if (k == 100) begin
        vectors++;
        if (throttled !== 4'b0000) begin miscompares++; $display("FAIL budget_replenish got=%b exp=0000", throttled); end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL budget_missing got=%0d left exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_hold_wait();
    set_budgets(1, 1, 1, 1);
    period = '0;
    empty = 4'b1011;
    consumed = 1'b0;
    apply_reset();
    exp_q.push_back(2'd2);
    next_cycle();
    empty = 4'b1111;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) next_cycle();
      vectors++;
      if (enable !== 1'b1 || id !== 2'd2 || has_been_consumed !== 4'b0000) begin
        miscompares++;
        $display("FAIL hold k=%0d got en=%b id=%0d pop=%b exp en=1 id=2 pop=0000", k, enable, id, has_been_consumed);
      end
    end
    consumed = 1'b1;
    #1;
    exp_id = exp_q.pop_front();
    vectors++;
    if (id !== exp_id || has_been_consumed !== (4'b0001 << exp_id)) begin
      miscompares++;
      $display("FAIL hold_pop got id=%0d pop=%b exp id=%0d", id, has_been_consumed, exp_id);
    end
    next_cycle();
    vectors++;
    if (enable !== 1'b0 || has_been_consumed !== 4'b0000) begin
      miscompares++;
      $display("FAIL hold_release got en=%b pop=%b exp en=0 pop=0000", enable, has_been_consumed);
    end
    consumed = 1'b0;
  endtask

  task automatic test_wrap_consume();
    logic exp_en;
    set_budgets(3, 3, 3, 3);
    period = RS'(6);
    empty = 4'b1101;
    consumed = 1'b0;
    apply_reset();
    exp_q = {2'd1, 2'd1, 2'd1, 2'd1};
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      vectors++;
      if (enable !== 1'b1 || id !== 2'd1) begin
        miscompares++; $display("FAIL wrap_wait k=%0d got en=%b id=%0d exp en=1 id=1", k, enable, id);
      end
    end
    consumed = 1'b1;
    #1;
    exp_id = exp_q.pop_front();
    vectors++;
    if (has_been_consumed !== (4'b0001 << exp_id)) begin
      miscompares++; $display("FAIL wrap_pop got=%b exp id=%0d", has_been_consumed, exp_id);
    end
    next_cycle();
    period = RS'(200);
    vectors++;
    if (enable !== 1'b0 || throttled !== 4'b0000) begin
      miscompares++; $display("FAIL wrap_edge got en=%b thr=%b exp en=0 thr=0000", enable, throttled);
    end
    for (int k = 7; k <= 14; k++) begin
      next_cycle();
      exp_en = (k == 7 || k == 9 || k == 11);
      vectors++;
      if (enable !== exp_en) begin miscompares++; $display("FAIL wrap_enable k=%0d got=%b exp=%b", k, enable, exp_en); end
      if (enable === 1'b1 && exp_q.size() != 0) begin
        exp_id = exp_q.pop_front();
        vectors++;
        if (id !== exp_id) begin miscompares++; $display("FAIL wrap_grant k=%0d got=%0d exp=%0d", k, id, exp_id); end
      end
      if (k == 10) begin
        vectors++;
        if (throttled !== 4'b0000) begin miscompares++; $display("FAIL wrap_remaining got=%b exp=0000", throttled); end
      end
      if (k >= 12) begin
        vectors++;
        if (throttled !== 4'b0010) begin miscompares++; $display("FAIL wrap_exhausted k=%0d got=%b exp=0010", k, throttled); end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_missing got=%0d left exp=0", exp_q.size()); end
    exp_q.delete();
    consumed = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    set_budgets(1, 1, 1, 1);
    period = RS'(50);
    empty = 4'b0000;
    consumed = 1'b1;
    apply_reset();
    exp_q.push_back(2'd0);
    next_cycle();
    exp_id = exp_q.pop_front();
    vectors++;
    if (enable !== 1'b1 || id !== exp_id) begin
      miscompares++; $display("FAIL rst_first got en=%b id=%0d exp en=1 id=%0d", enable, id, exp_id);
    end
    next_cycle();
    vectors++;
    if (throttled !== 4'b0001) begin miscompares++; $display("FAIL rst_spent got=%b exp=0001", throttled); end
    next_cycle();
    vectors++;
    if (enable !== 1'b1 || id !== 2'd1) begin
      miscompares++; $display("FAIL rst_second got en=%b id=%0d exp en=1 id=1", enable, id);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (has_been_consumed !== 4'b0000) begin miscompares++; $display("FAIL rst_no_pop got=%b exp=0000", has_been_consumed); end
    next_cycle();
    vectors++;
    if (enable !== 1'b0 || id !== 2'd0 || has_been_consumed !== 4'b0000 || throttled !== 4'b0000 || state !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_drop got en=%b id=%0d pop=%b thr=%b st=%b exp en=0 id=0 pop=0000 thr=0000 st=0",
               enable, id, has_been_consumed, throttled, state);
    end
    reset = 1'b0;
    exp_q.push_back(2'd0);
    next_cycle();
    exp_id = exp_q.pop_front();
    vectors++;
    if (enable !== 1'b1 || id !== exp_id) begin
      miscompares++; $display("FAIL rst_restart got en=%b id=%0d exp en=1 id=%0d", enable, id, exp_id);
    end
  endtask

  task automatic test_work_conserving();
    logic wc;
    logic exp_en;
`ifdef WORK_CONSERVING_EN
    wc = 1'b1;
`else
    wc = 1'b0;
`endif
    set_budgets(1, 0, 0, 0);
    period = RS'(100);
    empty = 4'b1011;
    consumed = 1'b1;
    apply_reset();
    if (wc) exp_q = {2'd2, 2'd2, 2'd2, 2'd2};
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      exp_en = wc && (k % 2 == 1);
      vectors++;
      if (enable !== exp_en) begin miscompares++; $display("FAIL wc_enable k=%0d got=%b exp=%b", k, enable, exp_en); end
      vectors++;
      if (throttled !== 4'b1110) begin miscompares++; $display("FAIL wc_throttled k=%0d got=%b exp=1110", k, throttled); end
      if (enable === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL wc_extra_grant k=%0d got=%0d exp=none", k, id);
        end else begin
          exp_id = exp_q.pop_front();
          if (id !== exp_id) begin miscompares++; $display("FAIL wc_grant k=%0d got=%0d exp=%0d", k, id, exp_id); end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL wc_missing got=%0d left exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    empty = '1;
    budgets = '0;
    period = '0;
    consumed = 1'b0;
    test_reset();
    test_round_robin();
    test_budget();
    test_hold_wait();
    test_wrap_consume();
    test_reset_mid_wait();
    test_work_conserving();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
